hamming_decode_arbiter: RTL and testbench

Shares one Hamming(7,4) correction datapath among NUM_REQ requesters. Each cycle a round-robin arbiter grants one requester. Its codeword is syndrome-checked and single-bit-corrected. The result is registered into a one-deep output stage tagged with the requester id. Sits between the channel-side receivers and the downstream data consumer, replacing one decoder instance per receiver.

---
 rtl/hamming_pkg.sv | 22 ++
 rtl/hamming74_correct.sv | 27 ++
 rtl/hamming_decode_arbiter.sv | 132 +++++++++++++
 tb/tb_hamming_decode_arbiter.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/hamming_pkg.sv
// Shared types, data-bit positions and syndrome helper for the Hamming(7,4) decode arbiter.
package hamming_pkg;

  typedef logic [6:0] codeword_t;
  typedef logic [3:0] data_t;
  typedef logic [2:0] syndrome_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_t;

  // Data bits are gathered MSB first: {c6,c5,c4,c2}
  localparam int DATA_POS [4] = '{6, 5, 4, 2};

  function automatic syndrome_t syndrome(input codeword_t c);
    return {c[3] ^ c[4] ^ c[5] ^ c[6],
            c[1] ^ c[2] ^ c[5] ^ c[6],
            c[0] ^ c[2] ^ c[4] ^ c[6]};
  endfunction

endpackage

// File: rtl/hamming74_correct.sv
// Combinational Hamming(7,4) single-bit corrector: a non-zero syndrome names the bit to flip.
module hamming74_correct
  import hamming_pkg::*;
(
  input  codeword_t code_i,
  output codeword_t code_o,
  output data_t     data_o,
  output logic      err_o
);

  syndrome_t syn;
  codeword_t corr;

  always_comb begin
    syn  = syndrome(code_i);
    corr = code_i;
    err_o = 1'b0;
    if (syn != 3'd0) begin
      corr  = code_i ^ (codeword_t'(1) << (syn - 3'd1));
      err_o = 1'b1;
    end
  end

  assign code_o = corr;
  assign data_o = {corr[DATA_POS[0]], corr[DATA_POS[1]], corr[DATA_POS[2]], corr[DATA_POS[3]]};

endmodule

// File: rtl/hamming_decode_arbiter.sv
// Round-robin shared Hamming(7,4) decoder with a one-deep registered output stage.
// Optional saturating corrected-error counter enabled by HAMMING_ERR_CNT_EN.
module hamming_decode_arbiter
  import hamming_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [7*NUM_REQ-1:0] req_code,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [6:0]           out_code,
  output logic [3:0]           out_data,
  output logic [ID_W-1:0]      out_id,
  output logic                 out_err,
`ifdef HAMMING_ERR_CNT_EN
  output logic [CNT_W-1:0]     err_count,
  input  logic                 err_clr,
`endif
  output out_state_t           dbg_state
);

  // Handshake: a requester transfers on req_valid & req_ready; the output
  // stage is consumed on out_valid & out_ready and may reload in that cycle.

  out_state_t      state_q, state_d;
  logic [ID_W-1:0] last_q, last_d;
  logic [ID_W-1:0] grant_idx;
  logic            grant_found;
  logic            accept;
  logic            transfer;
  int              idx;

  codeword_t sel_code, corr_code;
  data_t     corr_data;
  logic      corr_err;

  codeword_t       out_code_q;
  data_t           out_data_q;
  logic [ID_W-1:0] out_id_q;
  logic            out_err_q;

  assign out_valid = (state_q == ST_FULL);
  assign accept    = !out_valid || out_ready;

  // Circular search starting just after the last granted requester
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_q) + k) % NUM_REQ;
      if (!grant_found && req_valid[idx]) begin
        grant_found = 1'b1;
        grant_idx   = ID_W'(idx);
      end
    end
  end

  assign transfer  = grant_found && accept && !reset;
  assign req_ready = transfer ? (NUM_REQ'(1) << grant_idx) : '0;
  assign sel_code  = req_code[int'(grant_idx)*7 +: 7];
  assign last_d    = transfer ? grant_idx : last_q;

  hamming74_correct u_correct (
    .code_i (sel_code),
    .code_o (corr_code),
    .data_o (corr_data),
    .err_o  (corr_err)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (transfer) state_d = ST_FULL;
      ST_FULL:  if (out_ready && !transfer) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_EMPTY;
      last_q     <= ID_W'(NUM_REQ - 1);
      out_code_q <= '0;
      out_data_q <= '0;
      out_id_q   <= '0;
      out_err_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      if (transfer) begin
        out_code_q <= corr_code;
        out_data_q <= corr_data;
        out_id_q   <= grant_idx;
        out_err_q  <= corr_err;
      end
    end
  end

  assign out_code  = out_code_q;
  assign out_data  = out_data_q;
  assign out_id    = out_id_q;
  assign out_err   = out_err_q;
  assign dbg_state = state_q;

`ifdef HAMMING_ERR_CNT_EN
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_clr) begin
      err_cnt_d = '0;
    end else if (transfer && corr_err && (err_cnt_q != {CNT_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) err_cnt_q <= '0;
    else       err_cnt_q <= err_cnt_d;
  end

  assign err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_hamming_decode_arbiter.sv
// Directed self-checking bench for hamming_decode_arbiter (counter checks under HAMMING_ERR_CNT_EN).
module tb_hamming_decode_arbiter;
  import hamming_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
`ifdef HAMMING_ERR_CNT_EN
  localparam int CNT_W   = 2;
`else
  localparam int CNT_W   = 16;
`endif

  logic                 clk;
  logic                 reset;
  logic [NUM_REQ-1:0]   req_valid;
  logic [7*NUM_REQ-1:0] req_code;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 out_valid;
  logic                 out_ready;
  logic [6:0]           out_code;
  logic [3:0]           out_data;
  logic [ID_W-1:0]      out_id;
  logic                 out_err;
  out_state_t           dbg_state;
`ifdef HAMMING_ERR_CNT_EN
  logic [CNT_W-1:0]     err_count;
  logic                 err_clr;
`endif

  int checks;
  int failures;
  logic [31:0] exp_q[$];

  // Valid codewords per requester with hand-derived data {c6,c5,c4,c2}
  logic [6:0] code_tab [4] = '{7'h00, 7'h55, 7'h7F, 7'h2A};
  logic [3:0] data_tab [4] = '{4'b0000, 4'b1011, 4'b1111, 4'b0100};

  hamming_decode_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W),
    .CNT_W   (CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_code  (req_code),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_code  (out_code),
    .out_data  (out_data),
    .out_id    (out_id),
    .out_err   (out_err),
`ifdef HAMMING_ERR_CNT_EN
    .err_count (err_count),
    .err_clr   (err_clr),
`endif
    .dbg_state (dbg_state)
  );

  // Clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled here
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_code(input int i, input logic [6:0] c);
    req_code[i*7 +: 7] = c;
  endtask

  task automatic check_out(input string tag, input logic [6:0] c, input logic [3:0] d,
                           input logic [ID_W-1:0] id, input logic e);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_code"},  32'(out_code),  32'(c));
    check({tag, "_data"},  32'(out_data),  32'(d));
    check({tag, "_id"},    32'(out_id),    32'(id));
    check({tag, "_err"},   32'(out_err),   32'(e));
  endtask

  initial begin
    logic [31:0] exp_id;
    checks    = 0;
    failures  = 0;
    reset     = 1'b1;
    req_valid = '0;
    req_code  = '0;
    out_ready = 1'b1;
`ifdef HAMMING_ERR_CNT_EN
    err_clr   = 1'b0;
`endif

    // Reset state, with requesters pending to confirm no grant during reset
    tick();
    tick();
    req_valid = 4'b1111;
    #1;
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_code",  32'(out_code),  32'd0);
    check("rst_data",  32'(out_data),  32'd0);
    check("rst_id",    32'(out_id),    32'd0);
    check("rst_err",   32'(out_err),   32'd0);
`ifdef HAMMING_ERR_CNT_EN
    check("rst_cnt",   32'(err_count), 32'd0);
`endif
    req_valid = '0;
    reset = 1'b0;

    // Clean codeword from requester 0
    req_valid = 4'b0001;
    set_code(0, 7'h55);
    #1;
    check("r0_ready", 32'(req_ready), 32'b0001);
    tick();
    req_valid = '0;
    check_out("r0", 7'h55, 4'b1011, 2'd0, 1'b0);

    // Requester 2 with bit 4 flipped
    req_valid = 4'b0100;
    set_code(2, 7'h45);
    #1;
    check("r2_ready", 32'(req_ready), 32'b0100);
    tick();
    req_valid = '0;
    check_out("r2", 7'h55, 4'b1011, 2'd2, 1'b1);
`ifdef HAMMING_ERR_CNT_EN
    check("r2_cnt", 32'(err_count), 32'd1);
`endif
    tick();
    check("drain_valid", 32'(out_valid), 32'd0);

    // Requester 3 alone moves the pointer to 3
    req_valid = 4'b1000;
    set_code(3, 7'h2A);
    tick();
    check_out("r3", 7'h2A, 4'b0100, 2'd3, 1'b0);

    // All requesters valid: ids rotate 0,1,2,3,0,1,2,3 with no gaps
    for (int i = 0; i < 4; i++) set_code(i, code_tab[i]);
    req_valid = 4'b1111;
    for (int j = 0; j < 8; j++) exp_q.push_back(32'(j % 4));
    #1;
    check("rr_ready0", 32'(req_ready), 32'b0001);
    for (int j = 0; j < 8; j++) begin
      tick();
      exp_id = exp_q.pop_front();
      check_out("rr", code_tab[exp_id[1:0]], data_tab[exp_id[1:0]], exp_id[1:0], 1'b0);
      check("rr_next_ready", 32'(req_ready), 32'(4'b0001 << ((j + 1) % 4)));
    end

    // Stall while FULL: outputs hold, no grants, pointer stays at 3
    out_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      #1;
      check("stall_ready", 32'(req_ready), 32'd0);
      tick();
      check_out("stall", code_tab[3], data_tab[3], 2'd3, 1'b0);
    end
    out_ready = 1'b1;
    #1;
    check("resume_ready", 32'(req_ready), 32'b0001);
    tick();
    check_out("resume", code_tab[0], data_tab[0], 2'd0, 1'b0);

    // Reset while FULL with everyone pending; pointer was 0 so 1 would be next otherwise
    reset = 1'b1;
    tick();
    check("mrst_valid", 32'(out_valid), 32'd0);
    check("mrst_ready", 32'(req_ready), 32'd0);
    reset = 1'b0;
    #1;
    check("mrst_first_ready", 32'(req_ready), 32'b0001);
    tick();
    check_out("mrst_first", code_tab[0], data_tab[0], 2'd0, 1'b0);

    // Empty stage accepts even with out_ready low
    req_valid = '0;
    tick();
    check("empty_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b0;
    req_valid = 4'b0010;
    #1;
    check("empty_accept", 32'(req_ready), 32'b0010);
    tick();
    req_valid = '0;
    check_out("empty_load", code_tab[1], data_tab[1], 2'd1, 1'b0);
    out_ready = 1'b1;
    tick();
    check("empty_drain", 32'(out_valid), 32'd0);

`ifdef HAMMING_ERR_CNT_EN
    // Saturating counter with CNT_W = 2, then clear beating a simultaneous error
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("cnt_clr0", 32'(err_count), 32'd0);
    set_code(0, 7'h54);
    req_valid = 4'b0001;
    for (int j = 0; j < 5; j++) begin
      tick();
      check("cnt_err_flag", 32'(out_err), 32'd1);
      check("cnt_code", 32'(out_code), 32'h55);
      check("cnt_seq", 32'(err_count), (j < 3) ? 32'(j + 1) : 32'd3);
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    req_valid = '0;
    check("cnt_clr_pri", 32'(err_count), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
